// File: rtl/rupt_sched_pkg.sv
// +----------------------------------------------------------------------+
// | rupt_pkg                                                             |
// | Shared types, source indices and vector helper for the RUPT          |
// | scheduler.                                                           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package rupt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2,
        INSVC = 2'd3
    } rupt_state_t;

    localparam int          C_NRUPT    = 10;
    localparam logic [11:0] C_VEC_BASE = 12'o4000;

    localparam int T6RUPT   = 0;
    localparam int T5RUPT   = 1;
    localparam int T3RUPT   = 2;
    localparam int T4RUPT   = 3;
    localparam int KEYRUPT1 = 4;
    localparam int KEYRUPT2 = 5;
    localparam int UPRUPT   = 6;
    localparam int DOWNRUPT = 7;
    localparam int RADARUPT = 8;
    localparam int HANDRUPT = 9;

    // Trap address for source id at the default base: base + 4*(id+1).
    function automatic logic [11:0] rupt_vector(input logic [3:0] id);
        return C_VEC_BASE + {6'd0, id, 2'b00} + 12'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rupt_sched_prio_enc.sv
// +----------------------------------------------------------------------+
// | rupt_prio_enc                                                        |
// | Lowest-index-wins priority encoder with a valid flag.                |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module rupt_prio_enc #(
    parameter int NRUPT = 10,
    parameter int IDX_W = 4
) (
    input  logic [NRUPT-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        // Scan downward so the lowest set index is the last to write.
        for (int i = NRUPT - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rupt_sched.sv
// +----------------------------------------------------------------------+
// | rupt_sched                                                           |
// | Interrupt scheduler: latches sources, requests insertion at NISQ,    |
// | completes the KRPT handshake and watches for RUPT LOCK.              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module rupt_sched
    import rupt_pkg::*;
#(
    parameter int               NRUPT    = C_NRUPT,
    parameter int               VEC_W    = 12,
    parameter logic [VEC_W-1:0] VEC_BASE = 12'o4000,
    parameter logic [15:0]      LOCK_LIM = 16'd2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NRUPT-1:0] rupt_req,
    input  logic             inhint,
    input  logic             iip,
    input  logic             ext,
    input  logic             ovnhrp,
    input  logic             nisq,
    input  logic             krpt,
    output logic             rptset,
    output logic [3:0]       rupt_id,
    output logic [VEC_W-1:0] rupt_vec,
    output logic [NRUPT-1:0] pend,
    output logic             busy,
    output logic             rupt_lock
);

    rupt_state_t      r_state;
    rupt_state_t      w_nxt;
    logic [NRUPT-1:0] r_req_q;
    logic [NRUPT-1:0] r_pend;
    logic [NRUPT-1:0] w_set;
    logic [NRUPT-1:0] w_clr;
    logic             r_rptset;
    logic             r_busy;
    logic [3:0]       r_id;
    logic [VEC_W-1:0] r_vec;
    logic [15:0]      r_cnt;
    logic             r_lock;
    logic             w_allow;
    logic [3:0]       w_win;
    logic             w_win_vld;

    rupt_prio_enc #(
        .NRUPT (NRUPT),
        .IDX_W (4)
    ) u_prio (
        .req   (r_pend),
        .idx   (w_win),
        .valid (w_win_vld)
    );

    assign w_allow = w_win_vld & ~inhint & ~iip & ~ext & ~ovnhrp;
    assign w_set   = rupt_req & ~r_req_q;
    assign w_clr   = (r_state == FIRE && krpt) ? (NRUPT'(1) << r_id) : '0;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    if (w_allow) w_nxt = ARMED;
            ARMED:   if (!w_allow) w_nxt = IDLE;
                     else if (nisq) w_nxt = FIRE;
            FIRE:    if (krpt) w_nxt = INSVC;
            INSVC:   if (!iip) w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_req_q  <= '0;
            r_pend   <= '0;
            r_rptset <= 1'b0;
            r_busy   <= 1'b0;
            r_id     <= '0;
            r_vec    <= '0;
        end else begin
            r_state  <= w_nxt;
            r_req_q  <= rupt_req;
            // A new edge overrides the acknowledge clear on the same bit.
            r_pend   <= (r_pend & ~w_clr) | w_set;
            r_rptset <= (w_nxt == ARMED) || (w_nxt == FIRE);
            r_busy   <= (w_nxt != IDLE);
            if (r_state == ARMED && w_nxt == FIRE) begin
                r_id  <= w_win;
                r_vec <= VEC_BASE + VEC_W'(rupt_vector(w_win) - C_VEC_BASE);
            end
        end
    end

    // Lock watchdog runs on IIP alone, independent of the scheduler state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_lock <= 1'b0;
        end else begin
            if (!iip) begin
                r_cnt <= '0;
            end else if (r_cnt != LOCK_LIM) begin
                r_cnt <= r_cnt + 16'd1;
            end
            r_lock <= (r_cnt == LOCK_LIM);
        end
    end

    assign rptset    = r_rptset;
    assign rupt_id   = r_id;
    assign rupt_vec  = r_vec;
    assign pend      = r_pend;
    assign busy      = r_busy;
    assign rupt_lock = r_lock;

endmodule

`default_nettype wire

// File: tb/tb_rupt_sched.sv
// +----------------------------------------------------------------------+
// | tb_rupt_sched                                                        |
// | Directed and random checks of rupt_sched against a cycle model.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rupt_sched;

    localparam int          NR   = 10;
    localparam int          LIM  = 8;
    localparam logic [11:0] BASE = 12'o4000;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] rupt_req;
    logic          inhint, iip, ext, ovnhrp, nisq, krpt;
    logic          rptset, busy, rupt_lock;
    logic [3:0]    rupt_id;
    logic [11:0]   rupt_vec;
    logic [NR-1:0] pend;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0=idle 1=armed 2=fire 3=in service.
    int            m_phase;
    logic [NR-1:0] m_pend, m_prev_req;
    int            m_id;
    logic [11:0]   m_vec;
    int            m_cnt;
    logic          m_lock;

    rupt_sched #(
        .NRUPT    (NR),
        .VEC_W    (12),
        .VEC_BASE (BASE),
        .LOCK_LIM (16'(LIM))
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rupt_req  (rupt_req),
        .inhint    (inhint),
        .iip       (iip),
        .ext       (ext),
        .ovnhrp    (ovnhrp),
        .nisq      (nisq),
        .krpt      (krpt),
        .rptset    (rptset),
        .rupt_id   (rupt_id),
        .rupt_vec  (rupt_vec),
        .pend      (pend),
        .busy      (busy),
        .rupt_lock (rupt_lock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_edge();
        logic [NR-1:0] rises, ack;
        bit ok;
        if (!rst) begin
            m_phase = 0; m_pend = '0; m_prev_req = '0; m_id = 0; m_vec = '0;
            m_cnt = 0; m_lock = 1'b0;
            return;
        end
        rises = rupt_req & ~m_prev_req;
        ack   = '0;
        ok    = (m_pend != 0) && !inhint && !iip && !ext && !ovnhrp;
        case (m_phase)
            0: if (ok) m_phase = 1;
            1: if (!ok) m_phase = 0;
               else if (nisq) begin
                   m_phase = 2;
                   m_id    = lowest(m_pend);
                   m_vec   = BASE + 12'(4 * (m_id + 1));
               end
            2: if (krpt) begin
                   m_phase = 3;
                   ack[m_id] = 1'b1;
               end
            default: if (!iip) m_phase = 0;
        endcase
        m_pend     = (m_pend & ~ack) | rises;
        m_prev_req = rupt_req;
        m_lock     = (m_cnt == LIM);
        m_cnt      = iip ? ((m_cnt < LIM) ? m_cnt + 1 : LIM) : 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("rptset", 32'(rptset), 32'(m_phase == 1 || m_phase == 2));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("pend", 32'(pend), 32'(m_pend));
        chk("rupt_id", 32'(rupt_id), 32'(m_id));
        chk("rupt_vec", 32'(rupt_vec), 32'(m_vec));
        chk("rupt_lock", 32'(rupt_lock), 32'(m_lock));
    endtask

    task automatic quiet();
        rupt_req = '0; inhint = 0; iip = 0; ext = 0; ovnhrp = 0; nisq = 0; krpt = 0;
    endtask

    initial begin
        m_phase = 0; m_pend = '0; m_prev_req = '0; m_id = 0; m_vec = '0;
        m_cnt = 0; m_lock = 0;
        quiet();
        rst = 1'b0;
        step(); step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_vec", 32'(rupt_vec), 32'd0);
        rst = 1'b1;

        // Single source
        rupt_req = 10'b0000000100; step();
        chk("single_pend", 32'(pend), 32'b0000000100);
        rupt_req = '0; step();
        chk("single_rptset", 32'(rptset), 32'd1);
        nisq = 1; step();
        chk("single_id", 32'(rupt_id), 32'd2);
        chk("single_vec", 32'(rupt_vec), 32'(12'o4014));
        nisq = 0; krpt = 1; iip = 1; step();
        chk("single_clr", 32'(pend), 32'd0);
        krpt = 0; iip = 0; step();
        chk("single_idle", 32'(busy), 32'd0);

        // Priority
        rupt_req = (NR'(1) << 7) | (NR'(1) << 1); step();
        rupt_req = '0; step();
        nisq = 1; step();
        chk("prio_id1", 32'(rupt_id), 32'd1);
        chk("prio_vec1", 32'(rupt_vec), 32'(12'o4010));
        nisq = 0; krpt = 1; step();
        krpt = 0; step(); step();
        nisq = 1; step();
        chk("prio_id7", 32'(rupt_id), 32'd7);
        chk("prio_vec7", 32'(rupt_vec), 32'(12'o4040));
        nisq = 0; krpt = 1; step();
        krpt = 0; step();

        // Gating
        inhint = 1; rupt_req = 10'd1; step();
        rupt_req = '0; nisq = 1; step(); step();
        chk("gate_hold", 32'(rptset), 32'd0);
        nisq = 0; inhint = 0; step();
        chk("gate_rise", 32'(rptset), 32'd1);
        ext = 1; step();
        chk("gate_ext", 32'(rptset), 32'd0);
        ext = 0; step();
        nisq = 1; step();
        nisq = 0; krpt = 1; step();
        krpt = 0; step();

        // Set/clear collision on source 3
        rupt_req = 10'd8; step();
        rupt_req = '0; step();
        nisq = 1; step();
        nisq = 0; krpt = 1; rupt_req = 10'd8; step();
        chk("coll_pend3", 32'(pend[3]), 32'd1);
        krpt = 0; rupt_req = '0; step(); step();
        chk("coll_rearm", 32'(rptset), 32'd1);
        nisq = 1; step();
        nisq = 0; krpt = 1; step();
        krpt = 0; step(); step();

        // RUPT LOCK
        iip = 1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("lock_rise", 32'(rupt_lock), 32'(k >= 9));
        end
        iip = 0; step();
        chk("lock_hold", 32'(rupt_lock), 32'd1);
        step();
        chk("lock_fall", 32'(rupt_lock), 32'd0);

        // Reset mid-FIRE
        rupt_req = 10'd32; step();
        rupt_req = '0; step();
        nisq = 1; step();
        nisq = 0; rst = 1'b0; step();
        chk("rst_out", 32'({rptset, busy, rupt_lock, rupt_id, rupt_vec, pend}), 32'd0);
        rst = 1'b1; krpt = 1; step();
        chk("rst_krpt", 32'({busy, pend}), 32'd0);
        krpt = 0; step();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) rupt_req = rupt_req ^ NR'(1 << $urandom_range(0, NR - 1));
            inhint = ($urandom_range(0, 7) == 0);
            ext    = ($urandom_range(0, 9) == 0);
            ovnhrp = ($urandom_range(0, 11) == 0);
            nisq   = ($urandom_range(0, 2) == 0);
            krpt   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) iip = ~iip;
            rst    = ($urandom_range(0, 149) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
